// File: rtl/ct_uart_readback_if.sv
// Word-memory read port used by the ciphertext UART readback engine.
interface ct_uart_readback_if #(
  parameter int MEM_AW = 10
) ();
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/ct_uart_readback.sv
// Reads the ciphertext block from word memory and streams it big-endian over UART 8N1.
module ct_uart_readback #(
  parameter int CLKS_PER_BIT = 868,
  parameter int BASE_WORD    = 72,
  parameter int NUM_WORDS    = 4,
  parameter int MEM_AW       = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  ct_uart_readback_if.master     mem,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_baud;
  logic [2:0]        r_bit;
  logic [1:0]        r_b;
  logic [WW-1:0]     r_w;
  logic [31:0]       r_shift;
  logic              r_fin;
  logic              r_mem_rd;
  logic [MEM_AW-1:0] r_mem_addr;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  logic              w_baud_last;
  logic [7:0]        w_byte;
  logic              w_mem_rd_nxt;
  logic [MEM_AW-1:0] w_mem_addr_nxt;
  logic              w_tx_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_byte      = r_shift[{r_b, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_READ;
        else       w_state_nxt = S_IDLE;
      end
      S_READ:  w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_START;
      S_START: begin
        if (w_baud_last) w_state_nxt = S_DATA;
        else             w_state_nxt = S_START;
      end
      S_DATA: begin
        if (w_baud_last && (r_bit == 3'd7)) w_state_nxt = S_STOP;
        else                                w_state_nxt = S_DATA;
      end
      S_STOP: begin
        if (!w_baud_last)               w_state_nxt = S_STOP;
        else if (r_b != 2'd0)           w_state_nxt = S_START;
        else if (r_w != {WW{1'b0}})     w_state_nxt = S_READ;
        else                            w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud  <= {BW{1'b0}};
      r_bit   <= 3'd0;
      r_b     <= 2'd0;
      r_w     <= {WW{1'b0}};
      r_shift <= 32'd0;
      r_fin   <= 1'b0;
    end else begin
      if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
        r_baud <= w_baud_last ? {BW{1'b0}} : (r_baud + BW'(1));
      end else begin
        r_baud <= {BW{1'b0}};
      end
      if (r_state == S_DATA) begin
        if (w_baud_last) r_bit <= r_bit + 3'd1;
      end else begin
        r_bit <= 3'd0;
      end
      if ((r_state == S_IDLE) && start) begin
        r_w <= WW'(NUM_WORDS - 1);
      end else if ((r_state == S_STOP) && (w_state_nxt == S_READ)) begin
        r_w <= r_w - WW'(1);
      end
      if (r_state == S_LATCH) begin
        r_shift <= mem.mem_rdata;
        r_b     <= 2'd3;
      end else if ((r_state == S_STOP) && (w_state_nxt == S_START)) begin
        r_b <= r_b - 2'd1;
      end
      r_fin <= (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    end
  end

  // Memory strobes follow the next state so data lands in LATCH; line outputs lag the state by one cycle.
  always_comb begin
    w_mem_rd_nxt = (w_state_nxt == S_READ);
    if (w_state_nxt == S_READ) begin
      if (r_state == S_IDLE) w_mem_addr_nxt = MEM_AW'(BASE_WORD + NUM_WORDS - 1);
      else                   w_mem_addr_nxt = MEM_AW'(BASE_WORD) + MEM_AW'(r_w) - MEM_AW'(1);
    end else begin
      w_mem_addr_nxt = r_mem_addr;
    end
    case (r_state)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_byte[r_bit];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (r_state != S_IDLE);
    w_done_nxt = r_fin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd   <= 1'b0;
      r_mem_addr <= {MEM_AW{1'b0}};
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign mem.mem_rd   = r_mem_rd;
  assign mem.mem_addr = r_mem_addr;
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign done         = r_done;
endmodule

// File: tb/tb_ct_uart_readback.sv
// Directed bench for ct_uart_readback: UART decoder, memory model and hand-computed byte streams.
module tb_ct_uart_readback;
  localparam int CPB  = 4;
  localparam int BASE = 72;
  localparam int NW   = 4;
  localparam int AW   = 10;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic tx;
  logic busy;
  logic done;

  ct_uart_readback_if #(.MEM_AW(AW)) mif ();

  ct_uart_readback #(
    .CLKS_PER_BIT(CPB), .BASE_WORD(BASE), .NUM_WORDS(NW), .MEM_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mem(mif),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (mif.mem_rd) mif.mem_rdata <= mem[mif.mem_addr];
    else            mif.mem_rdata <= 32'hDEAD_BEEF;
  end

  int n_total;
  int n_bad;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: UART decoder (4 samples per bit) plus event logs, all sampled on the falling edge.
  int          ncyc = 0;
  logic [7:0]  rx_q[$];
  int          frame_t[$];
  int          done_q[$];
  int          start_q[$];
  logic [9:0]  rd_q[$];
  int          fr_err = 0;
  bit          m_act = 1'b0;
  int          m_s = 0;
  logic [7:0]  m_byte;
  logic        start_prev = 1'b0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (reset) begin
      m_act = 1'b0;
    end else begin
      if (done) done_q.push_back(ncyc);
      if (mif.mem_rd) rd_q.push_back(mif.mem_addr);
      if (start && !start_prev) start_q.push_back(ncyc);
      if (!m_act && !tx) begin
        m_act = 1'b1;
        m_s   = 0;
        frame_t.push_back(ncyc);
      end
      if (m_act) begin
        if (m_s / 4 == 0) begin
          if (tx) fr_err++;
        end else if (m_s / 4 == 9) begin
          if (!tx) fr_err++;
        end else if (m_s % 4 == 0) begin
          m_byte[m_s / 4 - 1] = tx;
        end else if (tx !== m_byte[m_s / 4 - 1]) begin
          fr_err++;
        end
        if (m_s == 39) begin
          rx_q.push_back(m_byte);
          m_act = 1'b0;
        end else begin
          m_s++;
        end
      end
    end
    start_prev = start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rx_q.delete();
    frame_t.delete();
    done_q.delete();
    start_q.delete();
    rd_q.delete();
    fr_err = 0;
  endtask

  task automatic load_ct();
    mem[72] = 32'h70b4c55a;
    mem[73] = 32'hd8cdb780;
    mem[74] = 32'h6a7b0430;
    mem[75] = 32'h69c4e0d8;
  endtask

  task automatic do_xfer(input bit extra);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      start = extra && ((k == 20) || (k == 200) || (k == 400));
      if ((done_q.size() >= 1) && (k > 400)) break;
    end
    start = 1'b0;
    repeat (20) tick();
  endtask

  task automatic check_stream(input string tag, input int base, input logic [7:0] e [16]);
    for (int i = 0; i < 16; i++) begin
      if (base + i < rx_q.size()) check_val(tag, {24'd0, rx_q[base + i]}, {24'd0, e[i]});
      else                        check_val(tag, 32'h0000_0100, {24'd0, e[i]});
    end
  endtask

  logic [7:0] exp_ct [16];
  logic [7:0] exp_bin [16];
  bit         found;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_ct = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
               8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    exp_bin = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'hff, 8'hff, 8'hff,
                8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'hff, 8'hff, 8'hff};
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: idle after reset
    check_val("rst_addr", {22'd0, mif.mem_addr}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      check_val("idle_tx", {31'd0, tx}, 32'd1);
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_done", {31'd0, done}, 32'd0);
      check_val("idle_rd", {31'd0, mif.mem_rd}, 32'd0);
    end

    // 2 + 3: ciphertext stream with ignored extra starts
    load_ct();
    clear_q();
    do_xfer(1'b1);
    check_val("t2_nbytes", rx_q.size(), 32'd16);
    check_stream("t2_byte", 0, exp_ct);
    check_val("t2_fr_err", fr_err, 32'd0);
    check_val("t2_nreads", rd_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) check_val("t2_addr", {22'd0, rd_q[i]}, 32'(75 - i));
    end
    check_val("t3_ndone", done_q.size(), 32'd1);
    check_val("t3_nstarts", start_q.size(), 32'd4);
    if ((done_q.size() > 0) && (start_q.size() > 0)) begin
      check_val("t2_done_lat", done_q[0] - start_q[0] - 1, 32'd649);
    end
    if ((frame_t.size() > 0) && (start_q.size() > 0)) begin
      check_val("t2_tx_lat", frame_t[0] - start_q[0] - 1, 32'd3);
    end
    check_val("t2_busy_end", {31'd0, busy}, 32'd0);

    // 4: all-zero / all-one words, bit timing
    mem[75] = 32'h0000_0000;
    mem[74] = 32'hFFFF_FFFF;
    mem[73] = 32'h0000_0000;
    mem[72] = 32'hFFFF_FFFF;
    clear_q();
    do_xfer(1'b0);
    check_val("t4_nbytes", rx_q.size(), 32'd16);
    check_stream("t4_byte", 0, exp_bin);
    check_val("t4_fr_err", fr_err, 32'd0);
    check_val("t4_ndone", done_q.size(), 32'd1);

    // 5: asynchronous reset in the middle of byte 5
    load_ct();
    clear_q();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if ((rx_q.size() == 5) && m_act && (m_s >= 8) && (m_s <= 30) && (tx == 1'b0)) begin
        found = 1'b1;
        break;
      end
    end
    check_val("t5_reached", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("t5_tx_async", {31'd0, tx}, 32'd1);
    check_val("t5_busy_async", {31'd0, busy}, 32'd0);
    check_val("t5_rd_async", {31'd0, mif.mem_rd}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_val("t5_busy_after", {31'd0, busy}, 32'd0);
    clear_q();
    do_xfer(1'b0);
    check_stream("t5_byte", 0, exp_ct);
    check_val("t5_fr_err", fr_err, 32'd0);
    check_val("t5_ndone", done_q.size(), 32'd1);

    // 6: start held high, back-to-back transfers
    clear_q();
    tick();
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (done_q.size() >= 1) break;
    end
    start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (done_q.size() >= 2) break;
    end
    repeat (20) tick();
    check_val("t6_ndone", done_q.size(), 32'd2);
    check_val("t6_nbytes", rx_q.size(), 32'd32);
    check_stream("t6_first", 0, exp_ct);
    check_stream("t6_second", 16, exp_ct);
    check_val("t6_nreads", rd_q.size(), 32'd8);
    check_val("t6_fr_err", fr_err, 32'd0);
    if ((frame_t.size() > 16) && (done_q.size() > 0)) begin
      check_val("t6_restart_lat", frame_t[16] - done_q[0], 32'd3);
    end else begin
      check_val("t6_restart_seen", frame_t.size(), 32'd17);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ct_uart_readback.md
Name: ct_uart_readback

Overview:
- Reads the AES ciphertext block out of the encryption SoC's word memory after the firmware has written it.
- Serializes the block over a UART 8N1 transmit line, so the board reports results without a simulator memory dump.
- Sits beside fpga_top_encryption on a second read port of the program/data RAM, triggered by a start pulse (button or CPU trap).
- Readback end of the CPU → memory ciphertext write path.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- BASE_WORD, 72: word index of CT[31:0] (byte address 0x120).
- NUM_WORDS, 4: number of 32-bit words sent; legal range ≥ 1.
- MEM_AW, 10: width of the word address.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- mem_rd  out  1  memory read strobe, one cycle per word
- mem_addr  out  MEM_AW  word address of the current read
- mem_rdata  in  32  read data, valid exactly one cycle after mem_rd
- tx  out  1  UART serial out, idle high
- busy  out  1  high from the accepted start until the final stop bit ends
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx=1, busy=0, done=0, mem_rd=0, mem_addr=0.
  - FSM goes to IDLE; all counters clear.
- All outputs are registered.
- FSM states: IDLE, READ, LATCH, START, DATA, STOP.
- IDLE:
  - tx=1.
  - start=1 → READ, with word index w=NUM_WORDS-1; busy rises next cycle.
- READ (1 cycle):
  - mem_rd=1, mem_addr=BASE_WORD+w.
  - → LATCH.
- LATCH (1 cycle):
  - Capture mem_rdata into a 32-bit shift word; set byte index b=3.
  - → START.
- START: tx=0 for CLKS_PER_BIT cycles → DATA.
- DATA:
  - Send 8 bits of byte b (bits [8b+7:8b]), LSB first.
  - Each bit is held CLKS_PER_BIT cycles → STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - If b>0: decrement b → START.
  - Else if w>0: decrement w → READ; tx stays high through READ and LATCH.
  - Else → IDLE, with done=1 for one cycle and busy=0 in that same cycle.
- Send order:
  - Highest word first (BASE_WORD+NUM_WORDS-1 down to BASE_WORD).
  - Most-significant byte first within a word.
  - The byte stream therefore equals the ciphertext printed big-endian.
- Timing:
  - tx falls 3 cycles after the clk edge that samples start.
  - Each word takes 2 + 40·CLKS_PER_BIT cycles.
  - Total from start accept to done = NUM_WORDS·(2 + 40·CLKS_PER_BIT) + 1 cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
  - No fractional baud correction.
- start while busy is ignored, with no queuing.
- start in the same cycle as done is accepted, because FSM is already IDLE.
- mem_rd is asserted only in READ: exactly NUM_WORDS pulses per transfer.
- mem_rdata is ignored outside LATCH.
- w and b underflow never occurs; the FSM checks for zero before decrementing.

Test Plan:
1. Reset, then hold idle 50 cycles → tx=1, busy=0, done=0, mem_rd=0 throughout.
2. CLKS_PER_BIT=4; mem[72..75]=70b4c55a, d8cdb780, 6a7b0430, 69c4e0d8; pulse start.
   - UART monitor decodes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
   - mem_rd pulses 4 times with addresses 75, 74, 73, 72.
   - done pulses once, 649 cycles after start accept.
3. During scenario 2, pulse start 3 more times while busy → byte stream and done count unchanged.
4. Bit timing with mem words 00000000 / FFFFFFFF:
   - Every start, data and stop bit lasts exactly 4 cycles.
   - Bytes decode as 00 / FF with no framing error.
5. Assert reset mid-DATA of byte 5 → tx=1 in the same cycle (asynchronous), busy=0.
   - A following start produces a complete, correct 16-byte stream.
6. Hold start high continuously → second transfer begins in the done cycle.
   - Second stream follows the first with tx low exactly 3 cycles after the done-cycle edge.
   - Both streams are correct.
